// File: rtl/serial_eq_ctrl_pkg.sv
// Shared definitions for serial_eq_ctrl: FSM state encoding and the
// default operand width.
package serial_eq_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_eq_ctrl_pkg

// File: rtl/serial_eq_ctrl_if.sv
// Request/response bundle for serial_eq_ctrl. The master side issues
// start with both operands; the slave side (the comparator) returns
// busy, the done pulse and the equality result Y.
interface serial_eq_ctrl_if #(
   parameter int WIDTH = serial_eq_ctrl_pkg::DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             Y;

   modport master (
      output start, A, B,
      input  busy, done, Y
   );

   modport slave (
      input  start, A, B,
      output busy, done, Y
   );

endinterface : serial_eq_ctrl_if

// File: rtl/serial_eq_ctrl_two_bit_equality.sv
// Shared 2-bit equality unit used by serial_eq_ctrl: Y is high when the
// two 2-bit slices match.
module twoBitEquality (
   input  logic [1:0] A,
   input  logic [1:0] B,
   output logic       Y
);

   assign Y = (A == B);

endmodule : twoBitEquality

// File: rtl/serial_eq_ctrl.sv
// Serial equality comparator. Operands are captured on start and compared
// two bits per cycle, LSB pair first, through one shared 2-bit equality
// unit. WIDTH must be even and >= 4.
//
// Build option: define SERIAL_EQ_EARLY_EXIT_EN to leave RUN on the first
// mismatching pair instead of always walking all WIDTH/2 pairs. The
// result Y is the same in both builds; only the latency differs.
module serial_eq_ctrl
   import serial_eq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   serial_eq_ctrl_if.slave bus
);

   localparam int NPAIR = WIDTH / 2;
   localparam int CNT_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPAIR - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             acc;
   logic             y_q;
   logic             pair_eq;
   logic             last_pair;

   twoBitEquality u_pair_eq (
      .A (sa[1:0]),
      .B (sb[1:0]),
      .Y (pair_eq)
   );

   assign last_pair = (cnt == CNT_LAST);

   // Next-state decision; start is only looked at in IDLE and DONE.
   always_comb begin
      // NOTE: assign every always_comb output a default before any branch,
      // otherwise a path that skips the assignment infers a latch.
      state_nxt = state;
      unique case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN: begin
            if (last_pair) begin
               state_nxt = DONE;
            end
`ifdef SERIAL_EQ_EARLY_EXIT_EN
            else if (!pair_eq) begin
               state_nxt = DONE;
            end
`endif
         end
         DONE: state_nxt = bus.start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state, pair counter, operand shift registers, accumulator and
   // result register, all in one clocked process.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the edge, independent of
      // statement order.
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sa    <= '0;
         sb    <= '0;
         acc   <= 1'b1;
         y_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  sa  <= bus.A;
                  sb  <= bus.B;
                  cnt <= '0;
                  acc <= 1'b1;
               end
            end
            RUN: begin
               acc <= acc & pair_eq;
               sa  <= sa >> 2;
               sb  <= sb >> 2;
               // Hold on the last pair so the counter never wraps.
               if (!last_pair) cnt <= cnt + CNT_ONE;
               // Y is loaded on the edge that enters DONE so it is valid
               // during the done pulse and only moves at that point.
               if (state_nxt == DONE) y_q <= acc & pair_eq;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.Y    = y_q;

endmodule : serial_eq_ctrl

// File: tb/tb_serial_eq_ctrl.sv
// Scoreboard bench for serial_eq_ctrl (WIDTH=16). The driver pushes the
// expected result, latency and busy length for each accepted start; an
// independent monitor pops and compares on every done pulse. Latency is
// counted in rising edges with the start-sampling edge as edge 1.
module tb_serial_eq_ctrl;
   import serial_eq_ctrl_pkg::*;

   localparam int WIDTH = 16;
`ifdef SERIAL_EQ_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   typedef struct {
      logic y;
      int   lat;
      int   start_cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   done_cnt;
   int   busy_run;
   int   overlap_err;
   int   ychg_err;
   logic prev_y;
   exp_t exp_q[$];

   serial_eq_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_eq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: protocol invariants every cycle, scoreboard compare on done.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_run = 0;
      end else begin
         if (bus.busy && bus.done) overlap_err++;
         if ((bus.Y !== prev_y) && !bus.done) ychg_err++;
         if (bus.busy) busy_run++;
         if (bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("result_y", int'(bus.Y), int'(e.y));
               check("latency", cyc - e.start_cyc + 1, e.lat);
               check("busy_cycles", busy_run, e.lat - 1);
            end
            busy_run = 0;
         end
      end
      prev_y = bus.Y;
   end

   // Issue one start pulse; operands are scrambled right after capture.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic exp_y, input int exp_lat);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      e.y         = exp_y;
      e.lat       = exp_lat;
      e.start_cyc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = ~a;
      bus.B     = b ^ 16'h5A5A;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
   endtask

   initial begin
      int dc;
      int n;
      exp_t e;
      cyc = 0; n_checks = 0; n_fail = 0; done_cnt = 0;
      busy_run = 0; overlap_err = 0; ychg_err = 0;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_y", int'(bus.Y), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Basic vectors.
      issue(16'hA5C3, 16'hA5C3, 1'b1, 9);             wait_idle();
      issue(16'h8000, 16'h0000, 1'b0, 9);             wait_idle();
      issue(16'h0001, 16'h0000, 1'b0, EE ? 2 : 9);    wait_idle();
      issue(16'hFFFF, 16'hFFFF, 1'b1, 9);             wait_idle();
      issue(16'h0300, 16'h0200, 1'b0, EE ? 6 : 9);    wait_idle();
      issue(16'h5555, 16'hD555, 1'b0, 9);             wait_idle();

      // Second start during RUN is ignored.
      issue(16'h1234, 16'h1234, 1'b1, 9);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = 16'h0000;
      bus.B = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      // Reset mid-RUN aborts without a done pulse; Y clears at once.
      issue(16'h1111, 16'h1111, 1'b1, 9);
      repeat (2) @(negedge clk);
      dc = done_cnt;
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_done", int'(bus.done), 0);
      check("abort_y", int'(bus.Y), 0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_no_done", done_cnt - dc, 0);
      issue(16'hBEEF, 16'hBEEF, 1'b1, 9);             wait_idle();

      // Back-to-back: start held during DONE with A=B=0.
      issue(16'h00FF, 16'h00FE, 1'b0, EE ? 2 : 9);
      n = 0;
      while (!bus.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done_seen", int'(bus.done), 1);
      bus.start = 1'b1;
      bus.A = '0;
      bus.B = '0;
      e.y = 1'b1;
      e.lat = 9;
      e.start_cyc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      repeat (3) @(negedge clk);
      check("busy_done_overlap", overlap_err, 0);
      check("y_changed_without_done", ychg_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_eq_ctrl

// File: doc/serial_eq_ctrl.md
SERIAL_EQ_CTRL -- requirements
Module: serial_eq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be even and >= 4.
REQ-002 Derived constant NPAIR = WIDTH/2, the number of 2-bit compare steps.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request pulse; SHALL be sampled only in IDLE or DONE.
REQ-006 A  input  WIDTH  first operand; SHALL be captured on the edge that accepts start.
REQ-007 B  input  WIDTH  second operand; SHALL be captured on the edge that accepts start.
REQ-008 busy  output  1  high while a comparison is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse marking Y valid.
REQ-010 Y  output  1  1 = A equal to B, 0 = not equal; held from the done pulse until the next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
REQ-012 IDLE with start=1 -> RUN: load shift registers SA<=A and SB<=B, set pair counter to 0 and accumulator to 1.
REQ-013 RUN, per cycle: compare SA[1:0] with SB[1:0] using the shared 2-bit equality unit; accumulator &= result; shift SA and SB right by 2; counter += 1.
REQ-014 RUN -> DONE after the compare at counter = NPAIR-1; the counter SHALL NOT wrap.
REQ-015 DONE: done=1 for exactly one cycle, Y <= accumulator, then -> IDLE, or -> RUN if start=1 in that same cycle.
REQ-016 Latency: done SHALL rise NPAIR+1 rising edges after the edge that samples start.
REQ-017 start during RUN SHALL be ignored; operands and the result in progress SHALL be unaffected.
REQ-018 A and B changing after capture SHALL NOT affect the result.
REQ-019 busy and done SHALL never be high in the same cycle.
REQ-020 Y SHALL change only on the cycle done rises, or on reset.

Reset
REQ-021 Asserting rst SHALL immediately force state=IDLE, busy=0, done=0, Y=0, counter=0, accumulator=1, SA=SB=0.
REQ-022 rst asserted mid-RUN SHALL abort the comparison with no done pulse.
REQ-023 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-024 Macro SERIAL_EQ_EARLY_EXIT_EN.
- Defined: a mismatch at pair k SHALL move RUN -> DONE immediately, so done rises k+2 edges after the start edge.
- Undefined: RUN SHALL always run NPAIR cycles, with fixed latency per REQ-016.
REQ-025 With either setting, Y SHALL be identical for identical operands.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 The block SHALL instantiate one sub-module, twoBitEquality, as the shared 2-bit compare unit (ports A[1:0], B[1:0], Y). No other sub-modules.
REQ-028 The FSM, counter, shift registers and accumulator SHALL be in a single sequential process. The next-state logic SHALL be combinational.

Verification
REQ-029 WIDTH=16, A=B=16'hA5C3, start pulse -> done rises 9 edges later with Y=1; busy was high for 8 cycles.
REQ-030 A=16'h8000, B=16'h0000 (mismatch only in the top pair) -> Y=0; done rises at edge 9 in both macro settings.
REQ-031 Early-exit build, A=16'h0001, B=16'h0000 (mismatch at pair 0) -> done rises at edge 2 with Y=0. Non-early-exit build -> done rises at edge 9 with Y=0.
REQ-032 start re-pulsed at edge 3 of RUN with new operands -> ignored; the result reflects the first operands only.
REQ-033 rst asserted at edge 4 of RUN -> outputs are cleared immediately and no done pulse follows. A new start after reset yields a correct result at edge 9.
REQ-034 start held high during DONE with A=B=0 -> back-to-back operation; the second done arrives 9 edges after the DONE-cycle edge with Y=1.
